rank_classifier: RTL and testbench
==================================

# rank_classifier

Consumer end of the per-kernel XOR scoring interface. Each XOR kernel comparator produces one mismatch score per captured card-corner patch. This block collects one score per rank kernel for the current patch and tracks the best (lowest) and second-best scores. Once every kernel has reported, it emits a single classified rank with a confidence verdict for the downstream card-identification logic.

## Interface
Parameters:
- NUM_KERNELS, 13: number of rank kernels reporting per patch (A..K).
- KERNEL_SIZE, 1120: pixels per kernel (corner_width × rank_height); sets the score width.
- REJECT_THRESH, 280: a best score above this value is never confident.
- MIN_MARGIN, 40: minimum (second_best − best) required for confidence.

Derived widths:
- SCORE_W = $clog2(KERNEL_SIZE).
- IDX_W = $clog2(NUM_KERNELS).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- frame_start  in  1  one-cycle pulse; abandons any partial collection and starts a new patch.
- score_valid  in  1  a score is presented this cycle.
- score_idx  in  IDX_W  kernel index of the presented score, 0..NUM_KERNELS−1.
- score  in  SCORE_W  mismatch count (lower is a better match).
- result_valid  out  1  one-cycle pulse when a classification completes.
- best_idx  out  IDX_W  winning kernel index; held until the next result.
- best_score  out  SCORE_W  winning score; held.
- margin  out  SCORE_W  second_best − best; held.
- confident  out  1  classification accepted; held.
- dup_err  out  1  sticky; set when a kernel index reports twice in one patch, or when score_idx ≥ NUM_KERNELS.

## Operation
- States: IDLE, COLLECT, DECIDE.
- IDLE:
  - An accepted score_valid records the score and goes to COLLECT.
  - frame_start stays in IDLE with the tracker cleared.
- COLLECT:
  - Each accepted score sets its bit in a NUM_KERNELS-bit seen mask.
  - Best/second tracking is updated per accepted score, as described below.
  - When the mask becomes all-ones, go to DECIDE.
- DECIDE (one cycle):
  - Latch best_idx, best_score, margin and confident.
  - Pulse result_valid.
  - Clear the mask, best and second tracking, then return to IDLE.
- Acceptance: score_valid with score_idx < NUM_KERNELS and its mask bit clear.
  - Any other score_valid is dropped and sets dup_err.
  - dup_err is cleared only by rst.
- Tracker reset values: best = second = all-ones (2^SCORE_W − 1); best_idx tracker = 0.
- Update rule for a new score s at index i:
  - If s < best, or s == best and i < best_idx: second ← best, then best ← s and best_idx ← i.
  - Otherwise, if s < second: second ← s.
  - Ties therefore go to the lower index, independent of arrival order.
- Margin is an unsigned subtraction, never negative by construction. With NUM_KERNELS == 1, second stays all-ones.
- confident = (best ≤ REJECT_THRESH) && (margin ≥ MIN_MARGIN).
- frame_start during COLLECT discards all partial state and returns to IDLE; no result is produced.
- frame_start in the same cycle as score_valid: the clear is applied first, and the score is accepted as the first score of the new patch.
- Reset values: result_valid 0, best_idx 0, best_score 0, margin 0, confident 0, dup_err 0, state IDLE, mask 0.

## Timing
- One score is accepted per cycle; there is no backpressure, and scores may arrive back-to-back or with gaps.
- result_valid asserts exactly 1 cycle after the cycle that accepts the final missing kernel.
- Held outputs update in the same cycle that result_valid is high.
- A score_valid arriving while in DECIDE belongs to the next patch. It is accepted and seeds the cleared tracker in that same cycle, so no scores are lost between patches.
- rst mid-collection restores all reset values on the next edge. No result_valid is produced.

## Configuration
- RANK_CLASSIFIER_MARGIN_EN defined:
  - Second-best tracking, the margin output and the MIN_MARGIN check are compiled in, as above.
- Not defined:
  - No second-best register is built.
  - margin is tied to 0.
  - confident = (best ≤ REJECT_THRESH) only.
  - All other behaviour is unchanged.

## Test plan
- Basic win, scores presented for idx 0..12: idx 0 = 100, all others 500 → result_valid 1 cycle after idx 12; best_idx 0, best_score 100, margin 400, confident 1.
- Tie and out-of-order arrival: order 12,11,…,0; idx 7 and idx 3 both score 90, all others 600 → best_idx 3, margin 0, confident 0 (0 confident 1 when RANK_CLASSIFIER_MARGIN_EN is undefined).
- Threshold reject: all 13 scores 300 except idx 5 = 290 → best_idx 5, margin 10, confident 0.
- Duplicate index: idx 4 sent twice (60 then 10), then the remaining 12 kernels at 700 → dup_err 1; best_score 60 (second copy ignored); exactly one result_valid pulse.
- Abort: 6 scores, then frame_start coincident with idx 9 = 50, then the 12 remaining kernels at 800 → no result for the aborted patch; the new result has best_idx 9, best_score 50.
- Reset mid-patch: 8 scores then rst → all outputs read their reset values; a following full patch of 13 scores classifies correctly.

Source files
------------

// File: rtl/rank_classifier_if.sv
// rank_classifier_if
// Bundles the per-kernel XOR score stream and the classification result.
//   master : score producer side (drives frame_start/score_valid/score_idx/score,
//            observes the result fields)
//   slave  : rank_classifier side (consumes scores, drives result fields)
// Widths: SCORE_W = $clog2(KERNEL_SIZE), IDX_W = $clog2(NUM_KERNELS).
interface rank_classifier_if #(
  parameter int NUM_KERNELS = 13,
  parameter int KERNEL_SIZE = 1120
);
  localparam int SCORE_W = $clog2(KERNEL_SIZE);
  localparam int IDX_W   = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1;

  logic               frame_start;
  logic               score_valid;
  logic [IDX_W-1:0]   score_idx;
  logic [SCORE_W-1:0] score;
  logic               result_valid;
  logic [IDX_W-1:0]   best_idx;
  logic [SCORE_W-1:0] best_score;
  logic [SCORE_W-1:0] margin;
  logic               confident;
  logic               dup_err;

  modport master (
    output frame_start, score_valid, score_idx, score,
    input  result_valid, best_idx, best_score, margin, confident, dup_err
  );

  modport slave (
    input  frame_start, score_valid, score_idx, score,
    output result_valid, best_idx, best_score, margin, confident, dup_err
  );
endinterface

// File: rtl/rank_classifier.sv
// rank_classifier
// Collects one mismatch score per rank kernel for the current card-corner
// patch, tracks the lowest (best) and second-lowest scores, and once every
// kernel has reported emits the winning rank with a confidence verdict.
//
// Ports:
//   clk  - system clock
//   rst  - synchronous, active-high reset
//   bus  - rank_classifier_if.slave
//            in : frame_start, score_valid, score_idx, score
//            out: result_valid (1-cycle pulse), best_idx, best_score, margin,
//                 confident (held until next result), dup_err (sticky)
//
// Optional feature macro: RANK_CLASSIFIER_MARGIN_EN
//   defined   : second-best tracking, margin output and MIN_MARGIN check.
//   undefined : no second-best register, margin tied to 0, confidence is
//               the reject threshold test only.
module rank_classifier #(
  parameter int NUM_KERNELS   = 13,
  parameter int KERNEL_SIZE   = 1120,
  parameter int REJECT_THRESH = 280,
  parameter int MIN_MARGIN    = 40
) (
  input  logic             clk,
  input  logic             rst,
  rank_classifier_if.slave bus
);

  localparam int SCORE_W = $clog2(KERNEL_SIZE);
  localparam int IDX_W   = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1;

  localparam logic [SCORE_W-1:0]     SCORE_MAX    = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0]     REJECT_LIM   = SCORE_W'(REJECT_THRESH);
  localparam logic [NUM_KERNELS-1:0] KERNEL_ONE   = NUM_KERNELS'(1);
  localparam logic [NUM_KERNELS-1:0] MASK_FULL    = {NUM_KERNELS{1'b1}};
  localparam logic [IDX_W:0]         KERNEL_COUNT = (IDX_W+1)'(NUM_KERNELS);
`ifdef RANK_CLASSIFIER_MARGIN_EN
  localparam logic [SCORE_W-1:0]     MARGIN_LIM   = SCORE_W'(MIN_MARGIN);
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DECIDE  = 2'd2
  } state_t;

  state_t               state_r;
  logic [NUM_KERNELS-1:0] mask_r;
  logic [SCORE_W-1:0]   trk_best_r;
  logic [IDX_W-1:0]     trk_idx_r;
  logic                 result_valid_r;
  logic [IDX_W-1:0]     best_idx_r;
  logic [SCORE_W-1:0]   best_score_r;
  logic [SCORE_W-1:0]   margin_r;
  logic                 confident_r;
  logic                 dup_err_r;

  logic                 clear_s;
  logic                 in_range_s;
  logic [NUM_KERNELS-1:0] onehot_s;
  logic [NUM_KERNELS-1:0] base_mask_s;
  logic [SCORE_W-1:0]   base_best_s;
  logic [IDX_W-1:0]     base_idx_s;
  logic                 accept_s;
  logic                 reject_s;
  logic                 wins_s;
  logic [NUM_KERNELS-1:0] mask_n_s;
  logic [SCORE_W-1:0]   best_n_s;
  logic [IDX_W-1:0]     idx_n_s;
  logic                 done_s;
  logic [SCORE_W-1:0]   margin_s;
  logic                 confident_s;
`ifdef RANK_CLASSIFIER_MARGIN_EN
  logic [SCORE_W-1:0]   trk_second_r;
  logic [SCORE_W-1:0]   base_second_s;
  logic [SCORE_W-1:0]   second_n_s;
`endif

  // Acceptance and best-score tracking. The DECIDE cycle and frame_start both
  // present a cleared tracker as the base, so a score arriving in either case
  // seeds the new patch in the same cycle.
  always_comb begin
    clear_s    = bus.frame_start || (state_r == ST_DECIDE);
    in_range_s = ({1'b0, bus.score_idx} < KERNEL_COUNT);
    onehot_s   = KERNEL_ONE << bus.score_idx;
    if (clear_s) begin
      base_mask_s = '0;
      base_best_s = SCORE_MAX;
      base_idx_s  = '0;
    end else begin
      base_mask_s = mask_r;
      base_best_s = trk_best_r;
      base_idx_s  = trk_idx_r;
    end
    accept_s = bus.score_valid && in_range_s && ((base_mask_s & onehot_s) == '0);
    reject_s = bus.score_valid && !accept_s;
    // Equal scores resolve to the lower kernel index regardless of arrival order.
    wins_s   = (bus.score < base_best_s) ||
               ((bus.score == base_best_s) && (bus.score_idx < base_idx_s));
    mask_n_s = base_mask_s;
    best_n_s = base_best_s;
    idx_n_s  = base_idx_s;
    if (accept_s) begin
      mask_n_s = base_mask_s | onehot_s;
      if (wins_s) begin
        best_n_s = bus.score;
        idx_n_s  = bus.score_idx;
      end else begin
        best_n_s = base_best_s;
      end
    end else begin
      mask_n_s = base_mask_s;
    end
    done_s = accept_s && (mask_n_s == MASK_FULL);
  end

  // Second-best tracking and the confidence verdict for the completing score.
  always_comb begin
`ifdef RANK_CLASSIFIER_MARGIN_EN
    if (clear_s) begin
      base_second_s = SCORE_MAX;
    end else begin
      base_second_s = trk_second_r;
    end
    second_n_s = base_second_s;
    if (accept_s && wins_s) begin
      second_n_s = base_best_s;
    end else if (accept_s && (bus.score < base_second_s)) begin
      second_n_s = bus.score;
    end else begin
      second_n_s = base_second_s;
    end
    // second never drops below best, so the subtraction cannot wrap.
    margin_s    = second_n_s - best_n_s;
    confident_s = (best_n_s <= REJECT_LIM) && (margin_s >= MARGIN_LIM);
`else
    margin_s    = '0;
    confident_s = (best_n_s <= REJECT_LIM);
`endif
  end

  // Patch FSM, tracker state, result latches and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      mask_r         <= '0;
      trk_best_r     <= SCORE_MAX;
      trk_idx_r      <= '0;
`ifdef RANK_CLASSIFIER_MARGIN_EN
      trk_second_r   <= SCORE_MAX;
`endif
      result_valid_r <= 1'b0;
      best_idx_r     <= '0;
      best_score_r   <= '0;
      margin_r       <= '0;
      confident_r    <= 1'b0;
      dup_err_r      <= 1'b0;
    end else begin
      mask_r         <= mask_n_s;
      trk_best_r     <= best_n_s;
      trk_idx_r      <= idx_n_s;
`ifdef RANK_CLASSIFIER_MARGIN_EN
      trk_second_r   <= second_n_s;
`endif
      // The result is latched on the edge that accepts the last kernel, so it
      // is visible during the DECIDE cycle.
      result_valid_r <= done_s;
      if (done_s) begin
        best_idx_r   <= idx_n_s;
        best_score_r <= best_n_s;
        margin_r     <= margin_s;
        confident_r  <= confident_s;
      end
      if (reject_s) begin
        dup_err_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (done_s)        state_r <= ST_DECIDE;
          else if (accept_s) state_r <= ST_COLLECT;
          else               state_r <= ST_IDLE;
        end
        ST_COLLECT: begin
          if (done_s)                state_r <= ST_DECIDE;
          else if (accept_s)         state_r <= ST_COLLECT;
          else if (bus.frame_start)  state_r <= ST_IDLE;
          else                       state_r <= ST_COLLECT;
        end
        ST_DECIDE: begin
          if (done_s)        state_r <= ST_DECIDE;
          else if (accept_s) state_r <= ST_COLLECT;
          else               state_r <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign bus.result_valid = result_valid_r;
  assign bus.best_idx     = best_idx_r;
  assign bus.best_score   = best_score_r;
  assign bus.margin       = margin_r;
  assign bus.confident    = confident_r;
  assign bus.dup_err      = dup_err_r;

endmodule

// File: tb/tb_rank_classifier.sv
// tb_rank_classifier
// Directed stimulus for rank_classifier with a scoreboard of expected results;
// each result_valid pulse is popped and compared, including its cycle.
module tb_rank_classifier;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   pulses   = 0;

  typedef struct {
    int idx;
    int bs;
    int mg;
    int cf;
    int at;
  } exp_t;

  exp_t sb[$];

  rank_classifier_if #(.NUM_KERNELS(13), .KERNEL_SIZE(1120)) bus ();

  rank_classifier #(
    .NUM_KERNELS(13), .KERNEL_SIZE(1120), .REJECT_THRESH(280), .MIN_MARGIN(40)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic put(input logic fs, input logic v, input int idx, input int s);
    @(negedge clk);
    bus.frame_start = fs;
    bus.score_valid = v;
    bus.score_idx   = 4'(idx);
    bus.score       = 11'(s);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) put(1'b0, 1'b0, 0, 0);
  endtask

  // Called right after driving the final kernel of a patch.
  task automatic expect_result(input int idx, input int bs, input int mg_m,
                               input int cf_m, input int cf_nm);
    exp_t e;
    e.idx = idx;
    e.bs  = bs;
`ifdef RANK_CLASSIFIER_MARGIN_EN
    e.mg  = mg_m;
    e.cf  = cf_m;
`else
    e.mg  = 0;
    e.cf  = cf_nm;
`endif
    e.at  = cyc + 1;
    sb.push_back(e);
  endtask

  // Result monitor: pops the scoreboard on every result pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.result_valid === 1'b1) begin
      pulses++;
      check("result_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("result_cycle", cyc, e.at);
        check("best_idx", 32'(bus.best_idx), e.idx);
        check("best_score", 32'(bus.best_score), e.bs);
        check("margin", 32'(bus.margin), e.mg);
        check("confident", 32'(bus.confident), e.cf);
      end
    end
  end

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    bus.frame_start = 1'b0;
    bus.score_valid = 1'b0;
    bus.score_idx   = 4'd0;
    bus.score       = 11'd0;
    repeat (2) @(negedge clk);
    check("rst_result_valid", 32'(bus.result_valid), 32'd0);
    check("rst_best_idx", 32'(bus.best_idx), 32'd0);
    check("rst_best_score", 32'(bus.best_score), 32'd0);
    check("rst_dup_err", 32'(bus.dup_err), 32'd0);
    rst = 1'b0;
    idle(2);

    // Basic win: idx 0 = 100, others 500.
    for (int i = 0; i < 13; i++) put(1'b0, 1'b1, i, (i == 0) ? 100 : 500);
    expect_result(0, 100, 400, 1, 1);
    idle(3);
    check("hold_best_score", 32'(bus.best_score), 32'd100);
    check("hold_result_valid", 32'(bus.result_valid), 32'd0);

    // Tie with reverse arrival: idx 7 and 3 both 90.
    for (int i = 12; i >= 0; i--) put(1'b0, 1'b1, i, (i == 7 || i == 3) ? 90 : 600);
    expect_result(3, 90, 0, 0, 1);
    idle(2);

    // Threshold reject: idx 5 = 290, others 300.
    for (int i = 0; i < 13; i++) put(1'b0, 1'b1, i, (i == 5) ? 290 : 300);
    expect_result(5, 290, 10, 0, 0);
    idle(2);
    check("dup_err_clear", 32'(bus.dup_err), 32'd0);

    // Duplicate index 4: second copy (10) ignored.
    put(1'b0, 1'b1, 4, 60);
    put(1'b0, 1'b1, 4, 10);
    for (int i = 0; i < 13; i++) if (i != 4) put(1'b0, 1'b1, i, 700);
    expect_result(4, 60, 640, 1, 1);
    idle(2);
    check("dup_err_set", 32'(bus.dup_err), 32'd1);

    // Abort: 6 low scores, then frame_start with idx 9 = 50.
    for (int i = 0; i < 6; i++) put(1'b0, 1'b1, i, 10);
    put(1'b1, 1'b1, 9, 50);
    for (int i = 0; i < 13; i++) if (i != 9) put(1'b0, 1'b1, i, 800);
    expect_result(9, 50, 750, 1, 1);
    idle(3);

    // Reset mid-patch.
    for (int i = 0; i < 8; i++) put(1'b0, 1'b1, i, 5);
    put(1'b0, 1'b0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_result_valid", 32'(bus.result_valid), 32'd0);
    check("mid_rst_best_idx", 32'(bus.best_idx), 32'd0);
    check("mid_rst_best_score", 32'(bus.best_score), 32'd0);
    check("mid_rst_margin", 32'(bus.margin), 32'd0);
    check("mid_rst_confident", 32'(bus.confident), 32'd0);
    check("mid_rst_dup_err", 32'(bus.dup_err), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 13; i++) put(1'b0, 1'b1, i, (i == 11) ? 20 : 100);
    expect_result(11, 20, 80, 1, 1);

    // Back-to-back patches: first score of the next patch lands in DECIDE.
    for (int i = 0; i < 13; i++) put(1'b0, 1'b1, i, (i == 0) ? 250 : 260);
    expect_result(0, 250, 10, 0, 1);
    for (int i = 0; i < 13; i++) put(1'b0, 1'b1, i, (i == 12) ? 30 : 200);
    expect_result(12, 30, 170, 1, 1);
    idle(5);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    check("result_pulses", 32'(pulses), 32'd8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
